// File: rtl/audio_pwm_dac.sv
// PWM audio DAC: turns each WIDTH-bit sample into a 1-bit PWM stream with 3-bit volume
// scaling and a click-free 8-step mute/unmute envelope; inputs are taken only at period boundaries.
module audio_pwm_dac #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_i,
  input  logic [2:0]       vol_i,
  input  logic             mute_i,
  output logic             pwm_o,
  output logic             period_start_o,
  output logic             active_o,
  output logic [3:0]       env_o
);

  // Products stay below 2^(WIDTH+3): sample*(vol+1) <= (2^WIDTH-1)*8, scaled*env <= (2^WIDTH-1)*8
  localparam int unsigned PROD_W  = WIDTH + 3;
  localparam logic [3:0]  ENV_MAX = 4'd8;

  typedef enum logic [1:0] {
    MUTED,
    RAMP_UP,
    PLAY,
    RAMP_DOWN
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q;
  logic [WIDTH-1:0]  duty_q, duty_d;
  logic [3:0]        env_q, env_d;
  logic [PROD_W-1:0] vol_prod;
  logic [PROD_W-1:0] duty_prod;
  logic [WIDTH-1:0]  scaled;
  logic              boundary;

  assign boundary = (cnt_q == {WIDTH{1'b1}});

  // Next envelope/state/duty; everything holds except on the boundary cycle
  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    duty_d    = duty_q;
    vol_prod  = PROD_W'(sample_i) * PROD_W'({1'b0, vol_i} + 4'd1);
    scaled    = WIDTH'(vol_prod >> 3);
    duty_prod = '0;
    if (boundary) begin
      if (mute_i) begin
        env_d = (env_q == 4'd0) ? 4'd0 : 4'(env_q - 4'd1);
      end else begin
        env_d = (env_q == ENV_MAX) ? ENV_MAX : 4'(env_q + 4'd1);
      end

      // Reversal mid-ramp simply continues from the current envelope value
      if (env_d == 4'd0) begin
        state_d = MUTED;
      end else if (env_d == ENV_MAX) begin
        state_d = PLAY;
      end else if (mute_i) begin
        state_d = RAMP_DOWN;
      end else begin
        state_d = RAMP_UP;
      end

      duty_prod = PROD_W'(scaled) * PROD_W'(env_d);
      duty_d    = WIDTH'(duty_prod >> 3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= {WIDTH{1'b1}};
      duty_q  <= '0;
      env_q   <= 4'd0;
      state_q <= MUTED;
    end else begin
      cnt_q   <= WIDTH'(cnt_q + 1'b1);
      duty_q  <= duty_d;
      env_q   <= env_d;
      state_q <= state_d;
    end
  end

  assign period_start_o = (cnt_q == '0);
  assign pwm_o          = (cnt_q < duty_q);
  assign active_o       = (env_q != 4'd0);
  assign env_o          = env_q;

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Scoreboard bench for audio_pwm_dac: a period-level model predicts envelope and high-cycle
// count of every PWM period; a monitor measures each period and compares against the queue.
module tb_audio_pwm_dac;

  localparam int unsigned WIDTH  = 8;
  localparam int          PERIOD = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sample = 8'd200;
  logic [2:0]       vol = 3'd7;
  logic             mute = 1'b0;
  logic             pwm;
  logic             period_start;
  logic             active;
  logic [3:0]       env;

  audio_pwm_dac #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample),
    .vol_i          (vol),
    .mute_i         (mute),
    .pwm_o          (pwm),
    .period_start_o (period_start),
    .active_o       (active),
    .env_o          (env)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int env;
    int duty;
  } exp_t;

  exp_t sb[$];

  // Reference model: position within the period, envelope, and per-period expectation
  int m_phase    = PERIOD - 1;
  int m_env      = 0;
  int m_scaled   = 0;
  bit m_in_reset = 1'b0;
  bit m_live     = 1'b0;
  exp_t m_e;

  initial forever begin
    @(posedge clk);
    m_live     = 1'b1;
    m_in_reset = rst;
    if (rst) begin
      m_phase = PERIOD - 1;
      m_env   = 0;
      sb.delete();
    end else begin
      if (m_phase == PERIOD - 1) begin
        if (mute) m_env = (m_env > 0) ? m_env - 1 : 0;
        else      m_env = (m_env < 8) ? m_env + 1 : 8;
        m_scaled = (int'(sample) * (int'(vol) + 1)) / 8;
        m_e.env  = m_env;
        m_e.duty = (m_scaled * m_env) / 8;
        sb.push_back(m_e);
      end
      m_phase = (m_phase + 1) % PERIOD;
    end
  end

  // Monitor: frames periods on period_start, counts high cycles, pops the scoreboard
  bit   in_prog  = 1'b0;
  int   ncyc     = 0;
  int   highs    = 0;
  int   env_seen = 0;
  int   act_seen = 0;
  int   pops     = 0;
  exp_t got_e;

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      if (m_in_reset) begin
        check("rst_pwm", int'(pwm), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_active", int'(active), 0);
        check("rst_env", int'(env), 0);
        in_prog = 1'b0;
      end else begin
        check("period_start", int'(period_start), int'(m_phase == 0));
        if (m_phase == PERIOD - 1) check("pwm_low_at_top", int'(pwm), 0);
        if (period_start) begin
          in_prog  = 1'b1;
          ncyc     = 1;
          highs    = int'(pwm);
          env_seen = int'(env);
          act_seen = int'(active);
        end else if (in_prog) begin
          ncyc++;
          highs += int'(pwm);
        end
        if (in_prog && ncyc == PERIOD) begin
          in_prog = 1'b0;
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            got_e = sb.pop_front();
            pops++;
            check("env", env_seen, got_e.env);
            check("active", act_seen, int'(got_e.env != 0));
            check("high_cycles", highs, got_e.duty);
          end
        end
      end
    end
  end

  task automatic run_periods(input int n);
    repeat (n * PERIOD) @(negedge clk);
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    @(negedge clk);
    while (m_phase != p && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    check("wait_phase", m_phase, p);
  endtask

  initial begin
    // Reset held for three edges with a non-idle input pattern
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_periods(10);                      // unmute ramp then steady play
    vol = 3'd3;                 run_periods(2);
    sample = 8'd0;              run_periods(2);
    sample = 8'd255; vol = 3'd7; run_periods(2);
    vol = 3'd0;                 run_periods(2);

    sample = 8'd200; vol = 3'd7; run_periods(2);
    mute = 1'b1;                run_periods(4);   // env 7..4
    mute = 1'b0;                run_periods(1);   // reversal to 5
    mute = 1'b1;                run_periods(7);   // down to 0 and stay
    mute = 1'b0;                run_periods(9);   // back to full

    // Mid-period input changes must not affect the running period
    wait_phase(100);
    sample = 8'd50;
    wait_phase(40);
    mute = 1'b1;
    @(negedge clk);
    mute = 1'b0;
    run_periods(2);

    // Synchronous reset mid-period, then a fresh ramp
    wait_phase(37);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_periods(3);

    repeat (24) begin
      repeat ($urandom_range(50, 400)) @(negedge clk);
      sample = 8'($urandom_range(0, 255));
      vol    = 3'($urandom_range(0, 7));
      mute   = 1'($urandom_range(0, 1));
    end
    run_periods(2);

    check("sb_drain", int'(sb.size() <= 1), 1);
    check("periods_checked", int'(pops >= 50), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_pwm_dac.md
Name: audio_pwm_dac

Overview:
- Downstream consumer of sound_generator's 8-bit soundOut.
- Converts each sample to a 1-bit PWM speaker/DAC output, with 3-bit volume scaling and a click-free mute/unmute envelope ramp.
- Samples are latched only at PWM period boundaries, so a duty cycle never changes mid-period.
- Sits between sound_generator and the audio output pin.

Parameters:
- WIDTH, 8: sample and PWM counter width. PWM period = 2^WIDTH clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_i  in  WIDTH  unsigned audio sample (driven by sound_generator soundOut)
- vol_i  in  3  volume; gain = (vol_i+1)/8
- mute_i  in  1  1 = ramp to silence, 0 = ramp to full
- pwm_o  out  1  PWM audio output
- period_start_o  out  1  one-cycle strobe at the first cycle of each PWM period
- active_o  out  1  high whenever env_q != 0
- env_o  out  4  current envelope value, 0..8

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - cnt_q = all ones (255).
  - duty_q = 0, env_q = 0, state = MUTED.
  - Resulting outputs: pwm_o=0, period_start_o=0, active_o=0, env_o=0.
  - Reset asserted mid-operation returns to these values on the next edge.
- Counter:
  - cnt_q increments by 1 every cycle and wraps 2^WIDTH-1 -> 0.
  - The boundary cycle is cnt_q == 2^WIDTH-1. The first boundary is the first edge after reset release.
- Outputs are combinational from registers:
  - period_start_o = (cnt_q == 0).
  - pwm_o = (cnt_q < duty_q), unsigned compare.
  - duty 0 gives a constant 0.
  - duty 255 gives high for 255 of 256 cycles (low only at cnt=255).
- At the boundary edge only, sample_i, vol_i and mute_i are sampled. Values are ignored at every other cycle.
- Envelope update at the boundary:
  - If mute_i=1: env_next = (env_q==0) ? 0 : env_q-1.
  - If mute_i=0: env_next = (env_q==8) ? 8 : env_q+1.
- State update at the boundary:
  - env_next==0 -> MUTED.
  - env_next==8 -> PLAY.
  - Otherwise: mute_i ? RAMP_DOWN : RAMP_UP.
  - A mid-ramp reversal continues from the current env value (no jump).
- Duty arithmetic at the boundary:
  - scaled = (sample_i * (vol_i+1)) >> 3. The product is 11-bit; take bits [10:3].
  - duty_q <= (scaled * env_next) >> 3. Max 255*8 >> 3 = 255, so no overflow.
- Latency:
  - A new sample/vol/mute value affects pwm_o from the first cycle (cnt=0) after the next boundary.
  - A full ramp 0->8 or 8->0 takes 8 periods.
- Registered at the boundary: env_o = env_q, active_o = (env_q != 0), state.
- States: MUTED, RAMP_UP, PLAY, RAMP_DOWN. State is observable via env_o/active_o. The verifier checks env_o progression.

Test Plan:
- Reset test: hold rst=1 for 3 cycles with mute_i=0 and sample_i=200.
  - During reset: pwm_o=0, period_start_o=0, active_o=0, env_o=0.
  - After release: the first boundary occurs on the first edge, then cnt=0 and period_start_o=1.
- Unmute ramp: mute_i=0, sample_i=200, vol_i=7 from reset.
  - env_o = 1,2,...,8 over 8 consecutive periods.
  - High-cycle counts per period = 25,50,75,100,125,150,175,200.
  - Then steady 200 high cycles per 256.
- Volume and extremes in PLAY:
  - vol_i=3, sample 200: 100 high cycles.
  - sample 0: pwm_o never high.
  - sample 255 with vol_i=7: 255 high cycles, low only at cnt=255.
  - vol_i=0 with sample 255: 31 high cycles.
- Mute ramp and reversal, from PLAY with sample 200, vol 7:
  - Set mute_i=1: env_o = 7,6,5,4 (duties 175,150,125,100).
  - Clear mute_i at env=4: env_o = 5 next (duty 125).
  - Re-mute through to 0: active_o drops the period env_o reaches 0, and pwm_o stays 0.
- Boundary-only sampling: in PLAY, change sample_i from 200 to 50 at cnt=100.
  - The current period still yields 200 high cycles.
  - The next period yields 50.
  - A 1-cycle mute_i pulse not coinciding with cnt=255 leaves env_o=8.
- Reset mid-operation: assert rst at cnt=37 in PLAY.
  - The next edge shows pwm_o=0, env_o=0, active_o=0.
  - After release, the ramp restarts from env=1.
